// File: rtl/div_ctrl_if.sv
// Request handshake between the EX stage and the HI/LO divide controller.
interface div_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_signed;
   logic [31:0] req_x;
   logic [31:0] req_y;

   modport master (
      output req_valid, req_signed, req_x, req_y,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_signed, req_x, req_y,
      output req_ready
   );
endinterface

// File: rtl/div_ctrl.sv
// Sequences DIV/DIVU requests to an external iterative divider and owns the architectural HI/LO
// registers, including MTHI/MTLO write-wins arbitration, pipeline flush and a watchdog timeout.
module div_ctrl (
   input  logic        clk,
   input  logic        reset,
   div_ctrl_if.slave   req,
   input  logic        flush,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_complete
);

   typedef enum logic [1:0] {StIdle, StRun, StCancel} state_t;

   localparam logic [5:0] TimeoutCycles = 6'd40;

   state_t     state;
   logic       kill_hi;
   logic       kill_lo;
   logic [5:0] cyc_cnt;
   logic       accept;
   logic       complete;
   logic       cnt_expire;

   assign req.req_ready = (state == StIdle) & ~flush;
   assign accept        = req.req_valid & req.req_ready;
   // div_complete only means something while the divider is being driven
   assign complete      = div_start & div_complete;
   assign cnt_expire    = (cyc_cnt + 6'd1) == TimeoutCycles;
   assign busy          = (state == StRun) | (state == StCancel);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         hi         <= 32'h0;
         lo         <= 32'h0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         div_start  <= 1'b0;
         div_signed <= 1'b0;
         div_x      <= 32'h0;
         div_y      <= 32'h0;
         kill_hi    <= 1'b0;
         kill_lo    <= 1'b0;
         cyc_cnt    <= 6'd0;
      end else begin
         done <= 1'b0;
         if (mthi_we) hi <= wdata;
         if (mtlo_we) lo <= wdata;

         unique case (state)
            StIdle: begin
               if (accept) begin
                  state      <= StRun;
                  div_start  <= 1'b1;
                  div_signed <= req.req_signed;
                  div_x      <= req.req_x;
                  div_y      <= req.req_y;
                  cyc_cnt    <= 6'd0;
               end
            end

            StRun, StCancel: begin
               cyc_cnt <= cyc_cnt + 6'd1;
               if (mthi_we) kill_hi <= 1'b1;
               if (mtlo_we) kill_lo <= 1'b1;

               if (complete || cnt_expire) begin
                  // A flushed or cancelled operation must never reach HI/LO
                  if (complete && state == StRun && !flush) begin
                     if (!kill_hi && !mthi_we) hi <= div_r;
                     if (!kill_lo && !mtlo_we) lo <= div_q;
                     done <= 1'b1;
                  end else if (!complete) begin
                     timeout <= 1'b1;
                  end
                  state     <= StIdle;
                  div_start <= 1'b0;
                  kill_hi   <= 1'b0;
                  kill_lo   <= 1'b0;
                  cyc_cnt   <= 6'd0;
               end else if (state == StRun && flush) begin
                  state <= StCancel;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus a randomized back-to-back run against
// an arithmetic reference and a variable-latency divider model.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush, mthi_we, mtlo_we;
   logic [31:0] wdata, hi, lo;
   logic        busy, done, timeout, div_start, div_signed;
   logic [31:0] div_x, div_y, div_q, div_r;
   logic        div_complete;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] hi_m, lo_m;

   always #5 clk = ~clk;

   div_ctrl_if req ();

   div_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .flush        (flush),
      .mthi_we      (mthi_we),
      .mtlo_we      (mtlo_we),
      .wdata        (wdata),
      .hi           (hi),
      .lo           (lo),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .div_start    (div_start),
      .div_signed   (div_signed),
      .div_x        (div_x),
      .div_y        (div_y),
      .div_q        (div_q),
      .div_r        (div_r),
      .div_complete (div_complete)
   );

   // Returns {remainder, quotient}; divide-by-zero yields q=all-ones, r=dividend.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x,
                                           input logic [31:0] y);
      logic [31:0] q, r;
      if (y == 32'h0) begin
         q = 32'hFFFFFFFF;
         r = x;
      end else if (sgn) begin
         q = 32'($signed(x) / $signed(y));
         r = 32'($signed(x) % $signed(y));
      end else begin
         q = x / y;
         r = x % y;
      end
      return {r, q};
   endfunction

   // Divider model: completes dv_lat cycles after div_start rises, or never when dv_hang is set.
   int unsigned dv_lat = 1;
   int unsigned dv_cnt;
   logic        dv_hang = 1'b0;
   logic        dv_cplt;
   logic        stray = 1'b0;
   assign div_complete = dv_cplt | stray;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dv_cnt  <= 0;
         dv_cplt <= 1'b0;
         div_q   <= 32'h0;
         div_r   <= 32'h0;
      end else if (div_start && !dv_cplt && !dv_hang) begin
         if (dv_cnt + 1 >= dv_lat) begin
            {div_r, div_q} <= ref_div(div_signed, div_x, div_y);
            dv_cplt        <= 1'b1;
            dv_cnt         <= 0;
         end else begin
            dv_cnt  <= dv_cnt + 1;
            dv_cplt <= 1'b0;
         end
      end else begin
         dv_cplt <= 1'b0;
         dv_cnt  <= 0;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        output bit acc);
      acc = 1'b0;
      req.req_valid  = 1'b1;
      req.req_signed = sgn;
      req.req_x      = x;
      req.req_y      = y;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = req.req_ready;
         step();
      end
      req.req_valid = 1'b0;
   endtask

   // Observes one operation from accept+1 until one cycle past the commit/return to idle.
   task automatic wait_done(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                            output int nbusy, output bit got, output bit stable,
                            output logic [3:0] after, output int ndone);
      nbusy  = 0;
      got    = 1'b0;
      stable = 1'b1;
      ndone  = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         nbusy++;
         if (div_start !== 1'b1 || {div_signed, div_x, div_y} !== {sgn, x, y}) stable = 1'b0;
         if (done) ndone++;
         got = div_complete;
         step();
         if (got) break;
      end
      after = {div_start, done, busy, req.req_ready};
      if (done) ndone++;
      step();
      if (done) ndone++;
   endtask

   task automatic test_reset();
      req.req_valid = 1'b0; req.req_signed = 1'b0; req.req_x = '0; req.req_y = '0;
      flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
      reset = 1'b0;
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      step();
      hi_m = '0; lo_m = '0;
      n_checks++;
      if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h want 0", {hi, lo});
      else n_pass++;
      n_checks++;
      if ({div_start, div_signed, div_x, div_y} !== 66'h0)
         $display("FAIL reset_div_bus: got %h want 0", {div_start, div_signed, div_x, div_y});
      else n_pass++;
      n_checks++;
      if ({done, timeout, busy, req.req_ready} !== 4'b0001)
         $display("FAIL reset_flags: got %b want 0001", {done, timeout, busy, req.req_ready});
      else n_pass++;
   endtask

   task automatic test_div_signed();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      dv_lat = 2;
      issue(1'b1, 32'hFFFFFFF9, 32'd2, acc);
      wait_done(1'b1, 32'hFFFFFFF9, 32'd2, nb, got, stable, aft, nd);
      n_checks++;
      if ({lo, hi} !== {32'hFFFFFFFD, 32'hFFFFFFFF})
         $display("FAIL div_signed_hilo: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", lo, hi);
      else n_pass++;
      n_checks++;
      if (nd !== 1) $display("FAIL div_signed_done_count: got %0d want 1", nd);
      else n_pass++;
      n_checks++;
      if ({acc, stable, aft} !== 6'b11_0101)
         $display("FAIL div_signed_handshake: got acc,stable,start,done,busy,ready=%b want 110101",
                  {acc, stable, aft});
      else n_pass++;
      n_checks++;
      if (nb !== 3) $display("FAIL div_signed_busy_cycles: got %0d want 3", nb);
      else n_pass++;
      hi_m = 32'hFFFFFFFF; lo_m = 32'hFFFFFFFD;
   endtask

   task automatic test_divu();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      dv_lat = 4;
      issue(1'b0, 32'hFFFFFFFF, 32'd16, acc);
      wait_done(1'b0, 32'hFFFFFFFF, 32'd16, nb, got, stable, aft, nd);
      n_checks++;
      if ({lo, hi} !== {32'h0FFFFFFF, 32'h0000000F})
         $display("FAIL divu_hilo: got lo=%h hi=%h want lo=0fffffff hi=0000000f", lo, hi);
      else n_pass++;
      n_checks++;
      if (nb !== 5 || aft[1] !== 1'b0)
         $display("FAIL divu_busy_window: got %0d cycles, busy_after=%b want 5, 0", nb, aft[1]);
      else n_pass++;
      hi_m = 32'h0000000F; lo_m = 32'h0FFFFFFF;
   endtask

   task automatic test_flush();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      flush = 1'b1; req.req_valid = 1'b1; req.req_x = 32'd5; req.req_y = 32'd1;
      @(negedge clk);
      n_checks++;
      if (req.req_ready !== 1'b0) $display("FAIL flush_idle_ready: got %b want 0", req.req_ready);
      else n_pass++;
      step();
      n_checks++;
      if ({busy, div_start} !== 2'b00)
         $display("FAIL flush_idle_accept: got busy,start=%b want 00", {busy, div_start});
      else n_pass++;
      flush = 1'b0; req.req_valid = 1'b0;
      mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h11111111;
      step();
      mthi_we = 1'b0; mtlo_we = 1'b0;
      dv_lat = 6;
      issue(1'b0, 32'd100, 32'd7, acc);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_checks++;
      if ({busy, req.req_ready} !== 2'b10)
         $display("FAIL flush_cancel_state: got busy,ready=%b want 10", {busy, req.req_ready});
      else n_pass++;
      wait_done(1'b0, 32'd100, 32'd7, nb, got, stable, aft, nd);
      n_checks++;
      if ({hi, lo} !== {32'h11111111, 32'h11111111})
         $display("FAIL flush_hilo: got hi=%h lo=%h want 11111111", hi, lo);
      else n_pass++;
      n_checks++;
      if (nd !== 0 || {got, aft[1], aft[0]} !== 3'b101)
         $display("FAIL flush_done: got done=%0d got,busy,ready=%b want 0, 101",
                  nd, {got, aft[1], aft[0]});
      else n_pass++;
      hi_m = 32'h11111111; lo_m = 32'h11111111;
   endtask

   task automatic test_mthi_kill();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      dv_lat = 5;
      issue(1'b0, 32'd9, 32'd4, acc);
      step();
      mthi_we = 1'b1; wdata = 32'hABCD0000;
      step();
      mthi_we = 1'b0;
      wait_done(1'b0, 32'd9, 32'd4, nb, got, stable, aft, nd);
      n_checks++;
      if ({hi, lo, nd} !== {32'hABCD0000, 32'd2, 32'd1})
         $display("FAIL mthi_kill: got hi=%h lo=%h done=%0d want abcd0000 2 1", hi, lo, nd);
      else n_pass++;
      // MTLO in the very cycle the divider completes
      dv_lat = 3;
      issue(1'b0, 32'd100, 32'd7, acc);
      repeat (3) step();
      mtlo_we = 1'b1; wdata = 32'h5A5A5A5A;
      step();
      mtlo_we = 1'b0;
      n_checks++;
      if ({lo, hi, done, busy} !== {32'h5A5A5A5A, 32'd2, 2'b10})
         $display("FAIL mtlo_coincident: got lo=%h hi=%h done=%b busy=%b want 5a5a5a5a 2 1 0",
                  lo, hi, done, busy);
      else n_pass++;
      step();
      dv_lat = 1;
      issue(1'b0, 32'd50, 32'd7, acc);
      wait_done(1'b0, 32'd50, 32'd7, nb, got, stable, aft, nd);
      n_checks++;
      if ({lo, hi} !== {32'd7, 32'd1})
         $display("FAIL kill_cleared: got lo=%h hi=%h want 7 1", lo, hi);
      else n_pass++;
   endtask

   task automatic test_div_zero_and_idle_complete();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      dv_lat = 2;
      issue(1'b1, 32'd1234, 32'd0, acc);
      wait_done(1'b1, 32'd1234, 32'd0, nb, got, stable, aft, nd);
      n_checks++;
      if ({lo, hi} !== {32'hFFFFFFFF, 32'd1234})
         $display("FAIL div_zero: got lo=%h hi=%h want ffffffff 000004d2", lo, hi);
      else n_pass++;
      mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hCAFEF00D;
      step();
      mthi_we = 1'b0; mtlo_we = 1'b0;
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      n_checks++;
      if ({hi, lo, done, busy} !== {32'hCAFEF00D, 32'hCAFEF00D, 2'b00})
         $display("FAIL idle_complete: got hi=%h lo=%h done=%b busy=%b want cafef00d x2 0 0",
                  hi, lo, done, busy);
      else n_pass++;
      hi_m = 32'hCAFEF00D; lo_m = 32'hCAFEF00D;
   endtask

   task automatic test_timeout_and_reset();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      dv_hang = 1'b1;
      issue(1'b0, 32'd1, 32'd1, acc);
      nb = 0; nd = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         nb++;
         if (done) nd++;
         step();
      end
      dv_hang = 1'b0;
      n_checks++;
      if (nb !== 40) $display("FAIL timeout_cycles: got %0d want 40", nb);
      else n_pass++;
      n_checks++;
      if ({timeout, div_start, req.req_ready, done} !== 4'b1010 || nd !== 0)
         $display("FAIL timeout_flags: got timeout,start,ready,done=%b dones=%0d want 1010 0",
                  {timeout, div_start, req.req_ready, done}, nd);
      else n_pass++;
      n_checks++;
      if ({hi, lo} !== {hi_m, lo_m})
         $display("FAIL timeout_hilo: got %h want %h", {hi, lo}, {hi_m, lo_m});
      else n_pass++;
      dv_lat = 1;
      issue(1'b0, 32'd8, 32'd2, acc);
      wait_done(1'b0, 32'd8, 32'd2, nb, got, stable, aft, nd);
      n_checks++;
      if ({timeout, lo} !== {1'b1, 32'd4})
         $display("FAIL timeout_sticky: got timeout=%b lo=%h want 1 4", timeout, lo);
      else n_pass++;
      dv_lat = 20;
      issue(1'b1, 32'd77, 32'd5, acc);
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({hi, lo, div_start, div_signed, div_x, div_y, done, timeout, busy} !== '0)
         $display("FAIL reset_mid_run: got hi=%h lo=%h start=%b sgn=%b x=%h y=%h done=%b to=%b busy=%b",
                  hi, lo, div_start, div_signed, div_x, div_y, done, timeout, busy);
      else n_pass++;
      @(negedge clk) reset = 1'b0;
      step();
      dv_lat = 2;
      issue(1'b1, 32'd77, 32'd5, acc);
      wait_done(1'b1, 32'd77, 32'd5, nb, got, stable, aft, nd);
      n_checks++;
      if ({lo, hi, timeout} !== {32'd15, 32'd2, 1'b0})
         $display("FAIL after_reset_op: got lo=%h hi=%h timeout=%b want f 2 0", lo, hi, timeout);
      else n_pass++;
      hi_m = 32'd2; lo_m = 32'd15;
   endtask

   task automatic test_back_to_back_random();
      bit acc, got, stable; int nb, nd; logic [3:0] aft;
      logic sgn; logic [31:0] x, y; logic [63:0] exp;
      for (int n = 0; n < 1000; n++) begin
         sgn = 1'($urandom);
         x   = $urandom;
         y   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (y == 32'h0 || y == 32'hFFFFFFFF) y = 32'd3;
         if ($urandom_range(0, 7) == 0) x = 32'($urandom_range(0, 100));
         dv_lat = $urandom_range(1, 4);
         repeat ($urandom_range(0, 3)) step();
         issue(sgn, x, y, acc);
         wait_done(sgn, x, y, nb, got, stable, aft, nd);
         exp = ref_div(sgn, x, y);
         n_checks++;
         if (lo !== exp[31:0] || !acc)
            $display("FAIL rand_lo[%0d]: got %h acc=%b want %h (sgn=%b x=%h y=%h)",
                     n, lo, acc, exp[31:0], sgn, x, y);
         else n_pass++;
         n_checks++;
         if (hi !== exp[63:32] || nd !== 1)
            $display("FAIL rand_hi[%0d]: got %h dones=%0d want %h 1 (sgn=%b x=%h y=%h)",
                     n, hi, nd, exp[63:32], sgn, x, y);
         else n_pass++;
      end
      n_checks++;
      if (timeout !== 1'b0) $display("FAIL rand_timeout: got %b want 0", timeout);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_div_signed();
      test_divu();
      test_flush();
      test_mthi_kill();
      test_div_zero_and_idle_complete();
      test_timeout_and_reset();
      test_back_to_back_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
